// File: rtl/glitc_i2c_bus_guard.sv
// rtl/glitc_i2c_bus_guard.sv - I2C pad guard: input filter, open-drain drive, stuck-bus detect and clear
//
// Purpose: sits between the I2C master and the SCL/SDA pads. It synchronizes and
// glitch-filters the pad inputs, turns master drive requests into open-drain pad
// enables, flags a stuck bus, and can recover it with SCL pulses followed by a STOP.
//
// Ports:
//   user_clk_i, user_rst_i         clock, synchronous active-high reset
//   scl_o/scl_oen_o, sda_o/sda_oen_o  master drive value / active-low enable
//   scl_i, sda_i                   filtered lines back to the master (1 while clearing)
//   scl_pad_i, sda_pad_i           raw pad inputs
//   scl_pad_oen, sda_pad_oen       active-low pad drive enables (pad value is always 0)
//   clear_req_i, auto_clear_en_i   manual clear pulse / clear on stuck detection
//   bus_stuck_o, clear_busy_o, clear_done_o, clear_fail_o, stuck_count_o  status
module glitc_i2c_bus_guard #(
  parameter int FILTER_LEN        = 4,
  parameter int STUCK_TIMEOUT     = 50000,
  parameter int CLEAR_HALF_PERIOD = 250,
  parameter int CLEAR_PULSES      = 9
) (
  input  logic       user_clk_i,
  input  logic       user_rst_i,
  input  logic       scl_o,
  input  logic       scl_oen_o,
  input  logic       sda_o,
  input  logic       sda_oen_o,
  output logic       scl_i,
  output logic       sda_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       scl_pad_oen,
  output logic       sda_pad_oen,
  input  logic       clear_req_i,
  input  logic       auto_clear_en_i,
  output logic       bus_stuck_o,
  output logic       clear_busy_o,
  output logic       clear_done_o,
  output logic       clear_fail_o,
  output logic [7:0] stuck_count_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int HCW = $clog2(CLEAR_HALF_PERIOD + 1);
  localparam int PCW = $clog2(CLEAR_PULSES + 1);

  typedef enum logic [2:0] {
    IDLE, PULSE_LO, PULSE_HI, STOP_A, STOP_B, STOP_C, DONE, FAIL
  } state_t;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]     meta_q, sync_q, filt_q, flip;
  logic [FCW-1:0] fcnt_q [2];

  state_t         state_q, state_d;
  logic [HCW-1:0] timer_q;
  logic [PCW-1:0] pulse_q;
  logic [15:0]    stuck_cnt_q;

  logic idle, last_cyc, start, pulse_inc;
  logic scl_rel, sda_rel, stuck_cond, stuck_evt;
  logic fsm_scl_oen, fsm_sda_oen;

  // A filtered line flips on the FILTER_LEN-th consecutive disagreeing sample.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i] = (sync_q[i] != filt_q[i]) && (fcnt_q[i] == FCW'(FILTER_LEN - 1));
    end
  end

  assign idle       = (state_q == IDLE);
  assign last_cyc   = (timer_q == HCW'(CLEAR_HALF_PERIOD - 1));
  assign scl_rel    = scl_oen_o | scl_o;
  assign sda_rel    = sda_oen_o | sda_o;
  assign stuck_cond = (!filt_q[0] && scl_rel) || (!filt_q[1] && filt_q[0] && sda_rel);
  // flip[0] is the filtered-SCL edge about to happen; it restarts the timeout.
  assign stuck_evt  = idle && stuck_cond && !flip[0] &&
                      (stuck_cnt_q == 16'(STUCK_TIMEOUT - 1));
  assign start      = idle && (clear_req_i || (stuck_evt && auto_clear_en_i));

  always_comb begin
    state_d     = state_q;
    fsm_scl_oen = 1'b1;
    fsm_sda_oen = 1'b1;
    pulse_inc   = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = PULSE_LO;
      PULSE_LO: begin
        fsm_scl_oen = 1'b0;
        if (last_cyc) state_d = PULSE_HI;
      end
      PULSE_HI: begin
        if (last_cyc) begin
          if (filt_q[1])                                state_d = STOP_A;
          else if (pulse_q == PCW'(CLEAR_PULSES - 1))   state_d = FAIL;
          else begin
            pulse_inc = 1'b1;
            state_d   = PULSE_LO;
          end
        end
      end
      STOP_A: begin
        fsm_scl_oen = 1'b0;
        fsm_sda_oen = 1'b0;
        if (last_cyc) state_d = STOP_B;
      end
      STOP_B: begin
        fsm_sda_oen = 1'b0;
        if (last_cyc) state_d = STOP_C;
      end
      STOP_C: begin
        if (last_cyc) state_d = (filt_q[0] && filt_q[1]) ? DONE : FAIL;
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      meta_q        <= 2'b11;
      sync_q        <= 2'b11;
      filt_q        <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
      state_q       <= IDLE;
      timer_q       <= '0;
      pulse_q       <= '0;
      stuck_cnt_q   <= '0;
      scl_pad_oen   <= 1'b1;
      sda_pad_oen   <= 1'b1;
      bus_stuck_o   <= 1'b0;
      clear_fail_o  <= 1'b0;
      stuck_count_o <= '0;
    end else begin
      meta_q <= {sda_pad_i, scl_pad_i};
      sync_q <= meta_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (flip[i]) begin
          filt_q[i] <= sync_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FCW'(1);
        end
      end

      state_q <= state_d;
      if (idle || (state_d != state_q)) timer_q <= '0;
      else                              timer_q <= timer_q + HCW'(1);

      if (start)          pulse_q <= '0;
      else if (pulse_inc) pulse_q <= pulse_q + PCW'(1);

      if (!idle || !stuck_cond || flip[0] || stuck_evt) stuck_cnt_q <= '0;
      else                                              stuck_cnt_q <= stuck_cnt_q + 16'd1;

      if (stuck_evt && (stuck_count_o != 8'hFF)) stuck_count_o <= stuck_count_o + 8'd1;

      if (stuck_evt)             bus_stuck_o <= 1'b1;
      else if (state_q == DONE)  bus_stuck_o <= 1'b0;

      if (start)                 clear_fail_o <= 1'b0;
      else if (state_q == FAIL)  clear_fail_o <= 1'b1;

      // Master requests only reach the pads while idle; a drive-high releases the line.
      scl_pad_oen <= idle ? scl_rel : fsm_scl_oen;
      sda_pad_oen <= idle ? sda_rel : fsm_sda_oen;
    end
  end

  assign clear_busy_o = !idle;
  assign clear_done_o = (state_q == DONE);
  assign scl_i        = idle ? filt_q[0] : 1'b1;
  assign sda_i        = idle ? filt_q[1] : 1'b1;

endmodule

// File: tb/tb_glitc_i2c_bus_guard.sv
// tb/tb_glitc_i2c_bus_guard.sv - event scoreboard bench for glitc_i2c_bus_guard
module tb_glitc_i2c_bus_guard;

  localparam int FL  = 4;
  localparam int TO  = 100;
  localparam int HP  = 10;
  localparam int NP  = 9;
  localparam int LAT = 2 + FL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic m_scl = 1'b1, m_scl_oen = 1'b1, m_sda = 1'b1, m_sda_oen = 1'b1;
  logic clear_req = 1'b0, auto_en = 1'b0;
  logic scl_ext = 1'b1, sda_ext = 1'b1;
  logic slave_req = 1'b0, slave_sda = 1'b1;
  int   slave_n = 1;

  logic scl_i, sda_i, scl_pad_oen, sda_pad_oen;
  logic bus_stuck, busy, done, fail;
  logic [7:0] scount;
  wire  scl_pad, sda_pad;

  // Open-drain wired-AND bus: DUT, external holder, and the SDA slave model.
  assign scl_pad = scl_pad_oen & scl_ext;
  assign sda_pad = sda_pad_oen & sda_ext & slave_sda;

  glitc_i2c_bus_guard #(
    .FILTER_LEN(FL), .STUCK_TIMEOUT(TO), .CLEAR_HALF_PERIOD(HP), .CLEAR_PULSES(NP)
  ) dut (
    .user_clk_i(clk), .user_rst_i(rst),
    .scl_o(m_scl), .scl_oen_o(m_scl_oen), .sda_o(m_sda), .sda_oen_o(m_sda_oen),
    .scl_i(scl_i), .sda_i(sda_i),
    .scl_pad_i(scl_pad), .sda_pad_i(sda_pad),
    .scl_pad_oen(scl_pad_oen), .sda_pad_oen(sda_pad_oen),
    .clear_req_i(clear_req), .auto_clear_en_i(auto_en),
    .bus_stuck_o(bus_stuck), .clear_busy_o(busy), .clear_done_o(done),
    .clear_fail_o(fail), .stuck_count_o(scount)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int sig; int val; int cyc; } ev_t;
  ev_t  expq[$];
  logic [8:0] mask = '0;
  int   n_vec = 0;
  int   n_err = 0;
  string names[9] = '{"scl_pad_oen", "sda_pad_oen", "scl_i", "sda_i", "bus_stuck_o",
                      "clear_busy_o", "clear_done_o", "clear_fail_o", "stuck_count_o"};

  // Monitor: every change on a watched output must match the next expected event.
  int   mon_cur[9];
  int   mon_prev[9];
  ev_t  mon_e;
  always @(negedge clk) begin
    mon_cur[0] = int'(scl_pad_oen); mon_cur[1] = int'(sda_pad_oen);
    mon_cur[2] = int'(scl_i);       mon_cur[3] = int'(sda_i);
    mon_cur[4] = int'(bus_stuck);   mon_cur[5] = int'(busy);
    mon_cur[6] = int'(done);        mon_cur[7] = int'(fail);
    mon_cur[8] = int'(scount);
    for (int i = 0; i < 9; i++) begin
      if (mask[i] && (mon_cur[i] != mon_prev[i])) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change: %s became %0d at cycle %0d, required no change",
                   names[i], mon_cur[i], cyc);
        end else begin
          mon_e = expq.pop_front();
          if (mon_e.sig != i || mon_e.val != mon_cur[i] || mon_e.cyc != cyc) begin
            n_err++;
            $display("FAIL event: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                     names[i], mon_cur[i], cyc, names[mon_e.sig], mon_e.val, mon_e.cyc);
          end
        end
      end
      mon_prev[i] = mon_cur[i];
    end
  end

  // SDA slave: holds SDA low while requested until it has seen slave_n SCL rising edges.
  initial begin
    logic last_scl;
    int   rises;
    last_scl = 1'b1;
    rises    = 0;
    forever begin
      @(posedge clk); #2;
      if (!slave_req)               rises = 0;
      else if (scl_pad && !last_scl) rises++;
      last_scl  = scl_pad;
      slave_sda = !(slave_req && rises < slave_n);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time bound exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int s, input int v, input int c);
    ev_t e;
    e.sig = s; e.val = v; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic drain(input string tag);
    n_vec++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d expected events missing, next %s=%0d at cycle %0d",
               tag, expq.size(), names[expq[0].sig], expq[0].val, expq[0].cyc);
      expq.delete();
    end
    mask = '0;
  endtask

  task automatic do_reset();
    mask = '0;
    m_scl = 1'b1; m_scl_oen = 1'b1; m_sda = 1'b1; m_sda_oen = 1'b1;
    clear_req = 1'b0; auto_en = 1'b0; scl_ext = 1'b1; sda_ext = 1'b1; slave_req = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
  endtask

  // Recovery timeline from the entry cycle s: n pulses of 2*HP, then the 3-phase STOP and DONE.
  task automatic push_recovery(input int s, input int n, input bit stuck_set, output int t_end);
    int t;
    for (int j = 0; j < n; j++) begin
      expect_ev(0, 0, s + 2*HP*j + 1);
      expect_ev(0, 1, s + 2*HP*j + HP + 1);
    end
    t = s + 2*HP*n;
    expect_ev(0, 0, t + 1);
    expect_ev(1, 0, t + 1);
    expect_ev(0, 1, t + HP + 1);
    expect_ev(1, 1, t + 2*HP + 1);
    expect_ev(6, 1, t + 3*HP);
    if (stuck_set) expect_ev(4, 0, t + 3*HP + 1);
    expect_ev(5, 0, t + 3*HP + 1);
    expect_ev(6, 0, t + 3*HP + 1);
    t_end = t + 3*HP + 1;
  endtask

  task automatic run_recover(input int n, input bit collide);
    int k, s, t_end;
    do_reset();
    auto_en = 1'b1;
    mask = 9'h17B;
    k = cyc;
    s = k + LAT + TO;
    expect_ev(3, 0, k + LAT);
    expect_ev(3, 1, s); expect_ev(4, 1, s); expect_ev(5, 1, s); expect_ev(8, 1, s);
    push_recovery(s, n, 1'b1, t_end);
    slave_n   = n;
    slave_req = 1'b1;
    if (collide) begin
      step(s - 1 - cyc);
      clear_req = 1'b1;
      step(1);
      clear_req = 1'b0;
    end
    step(t_end + 10 - cyc);
    drain(collide ? "collide" : "recover");
    slave_req = 1'b0;
    chk("recover_fail_flag", int'(fail), 0);
    chk("recover_stuck_count", int'(scount), 1);
    auto_en = 1'b0;
  endtask

  initial begin
    int k, s, f, t_end, w;
    logic [3:0] r;
    logic cur_scl, cur_sda, ns, nd;

    do_reset();
    chk("rst_scl_pad_oen", int'(scl_pad_oen), 1);
    chk("rst_sda_pad_oen", int'(sda_pad_oen), 1);
    chk("rst_scl_i", int'(scl_i), 1);
    chk("rst_sda_i", int'(sda_i), 1);
    chk("rst_bus_stuck", int'(bus_stuck), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_count", int'(scount), 0);

    // Pass-through: random master drive, pad enable next cycle, filtered line LAT later.
    mask = 9'h00F;
    cur_scl = 1'b1; cur_sda = 1'b1;
    for (int it = 0; it < 9; it++) begin
      r = 4'($urandom);
      if (it == 0) r = 4'b0011;
      if (it == 8) r = 4'b1111;
      ns = r[3] | r[2];
      nd = r[1] | r[0];
      k = cyc;
      if (ns != cur_scl) expect_ev(0, int'(ns), k + 1);
      if (nd != cur_sda) expect_ev(1, int'(nd), k + 1);
      if (ns != cur_scl) expect_ev(2, int'(ns), k + 1 + LAT);
      if (nd != cur_sda) expect_ev(3, int'(nd), k + 1 + LAT);
      {m_scl, m_scl_oen, m_sda, m_sda_oen} = r;
      cur_scl = ns; cur_sda = nd;
      step(12);
    end
    drain("passthrough");

    // Filter: low pulses shorter than FL vanish, longer ones pass delayed by LAT.
    mask = 9'h008;
    for (int it = 0; it < 8; it++) begin
      w = (it == 0) ? 3 : (it == 1) ? 6 : int'($urandom_range(1, 8));
      k = cyc;
      if (w >= FL) begin
        expect_ev(3, 0, k + LAT);
        expect_ev(3, 1, k + LAT + w);
      end
      sda_ext = 1'b0;
      step(w);
      sda_ext = 1'b1;
      step(20);
    end
    drain("filter");

    // SCL held low, no auto clear: one stuck event per timeout span.
    do_reset();
    mask = 9'h114;
    k = cyc;
    expect_ev(2, 0, k + LAT);
    expect_ev(4, 1, k + LAT + TO);
    expect_ev(8, 1, k + LAT + TO);
    expect_ev(8, 2, k + LAT + 2*TO);
    scl_ext = 1'b0;
    step(230);
    k = cyc;
    expect_ev(2, 1, k + LAT);
    scl_ext = 1'b1;
    step(20);
    drain("scl_stuck");
    chk("scl_stuck_sticky", int'(bus_stuck), 1);
    chk("scl_stuck_count", int'(scount), 2);

    // SDA stuck with auto recovery.
    run_recover(3, 1'b0);
    run_recover(int'($urandom_range(1, 8)), 1'b0);
    // Manual request coincident with the auto stuck event: a single clear.
    run_recover(int'($urandom_range(1, 8)), 1'b1);

    // Recovery fails: SDA permanently low, NP pulses, no STOP; a request mid-clear is ignored.
    do_reset();
    mask = 9'h0A3;
    k = cyc;
    s = k + 21;
    f = s + 2*HP*NP;
    expect_ev(5, 1, s);
    for (int j = 0; j < NP; j++) begin
      expect_ev(0, 0, s + 2*HP*j + 1);
      expect_ev(0, 1, s + 2*HP*j + HP + 1);
    end
    expect_ev(5, 0, f + 1);
    expect_ev(7, 1, f + 1);
    sda_ext = 1'b0;
    step(20);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    step(s + 50 - cyc);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    step(f + 20 - cyc);
    drain("fail");
    chk("fail_sticky", int'(fail), 1);
    chk("fail_busy", int'(busy), 0);
    sda_ext = 1'b1;
    step(10);

    // A new clear on a healthy bus clears the fail flag and completes after one pulse.
    mask = 9'h0E3;
    k = cyc;
    s = k + 1;
    expect_ev(5, 1, s);
    expect_ev(7, 0, s);
    push_recovery(s, 1, 1'b0, t_end);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    step(t_end + 10 - cyc);
    drain("reclear");

    // Reset during PULSE_LO releases the pads and clears all status the next cycle.
    do_reset();
    auto_en = 1'b1;
    mask = 9'h133;
    k = cyc;
    s = k + LAT + TO;
    expect_ev(4, 1, s); expect_ev(5, 1, s); expect_ev(8, 1, s);
    expect_ev(0, 0, s + 1);
    expect_ev(0, 1, s + 5); expect_ev(4, 0, s + 5); expect_ev(5, 0, s + 5); expect_ev(8, 0, s + 5);
    sda_ext = 1'b0;
    step(s + 4 - cyc);
    rst = 1'b1;
    step(1);
    chk("midrst_scl_pad_oen", int'(scl_pad_oen), 1);
    chk("midrst_sda_pad_oen", int'(sda_pad_oen), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(scount), 0);
    rst = 1'b0;
    step(3);
    drain("mid_reset");
    auto_en = 1'b0;
    sda_ext = 1'b1;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
